// File: rtl/capture_pkg.sv
// Shared types and default widths for the logic-analyzer capture sequencer.
package capture_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int CH_DEF     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;
endpackage

// File: rtl/capture_ctrl_if.sv
// Sample stream in (from strobe generator) and sample-RAM write port out.
// master = capture controller, slave = sample source / RAM side.
interface capture_ctrl_if import capture_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CH     = CH_DEF
) ();
    logic              sample_en;
    logic [CH-1:0]     data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [CH-1:0]     mem_wdata;

    modport master (input sample_en, data, output mem_we, mem_addr, mem_wdata);
    modport slave  (output sample_en, data, input mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/capture_ctrl_trig_match.sv
// Combinational trigger compare: per-channel mask, level and (with CAPTURE_EDGE_TRIG_EN) edge terms.
// No latency, no state; hit is valid whenever smp is.
module trig_match import capture_pkg::*; #(
    parameter int CH = CH_DEF
) (
    input  logic [CH-1:0] smp,
    input  logic [CH-1:0] prev,
    input  logic          prev_valid,
    input  logic [CH-1:0] mask,
    input  logic [CH-1:0] val,
    input  logic [CH-1:0] edge_sel,
    output logic          hit
);
    logic [CH-1:0] ch_ok;

`ifdef CAPTURE_EDGE_TRIG_EN
    always_comb begin
        ch_ok = '0;
        for (int i = 0; i < CH; i++) begin
            // An edge term needs a known previous sample at the opposite level.
            if (!mask[i])
                ch_ok[i] = 1'b1;
            else if (edge_sel[i])
                ch_ok[i] = prev_valid && (prev[i] != val[i]) && (smp[i] == val[i]);
            else
                ch_ok[i] = (smp[i] == val[i]);
        end
    end
`else
    wire unused_ok = ^{prev, prev_valid, edge_sel};
    assign ch_ok = ~mask | ~(smp ^ val);
`endif

    assign hit = &ch_ok;
endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger circular fill, trigger wait, post-trigger fill, done.
// Optional edge triggering is built when CAPTURE_EDGE_TRIG_EN is defined.
module capture_ctrl import capture_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CH     = CH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    capture_ctrl_if.master    bus,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic [CH-1:0]     trig_mask,
    input  logic [CH-1:0]     trig_val,
    input  logic [CH-1:0]     trig_edge,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);
    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] post_q;
    logic [CH-1:0]     mask_q;
    logic [CH-1:0]     val_q;
    logic [CH-1:0]     edge_q;
    logic [CH-1:0]     prev_q;
    logic              prev_valid;
    logic              hit;
    logic              wr_go;

    assign wr_go = bus.sample_en && !abort &&
                   (state == ST_PRE || state == ST_ARMED || state == ST_POST);

`ifdef CAPTURE_EDGE_TRIG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_q     <= '0;
            prev_q     <= '0;
            prev_valid <= 1'b0;
        end else if (!abort && arm && (state == ST_IDLE || state == ST_DONE)) begin
            edge_q     <= trig_edge;
            prev_valid <= 1'b0;
        end else if (wr_go) begin
            prev_q     <= bus.data;
            prev_valid <= 1'b1;
        end
    end
`else
    wire unused_ok = ^trig_edge;
    assign edge_q     = '0;
    assign prev_q     = '0;
    assign prev_valid = 1'b0;
`endif

    trig_match #(.CH(CH)) u_match (
        .smp        (bus.data),
        .prev       (prev_q),
        .prev_valid (prev_valid),
        .mask       (mask_q),
        .val        (val_q),
        .edge_sel   (edge_q),
        .hit        (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_ptr        <= '0;
            cnt           <= '0;
            pre_q         <= '0;
            post_q        <= '0;
            mask_q        <= '0;
            val_q         <= '0;
            trig_addr     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (wr_go) begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= wr_ptr;
                bus.mem_wdata <= bus.data;
                wr_ptr        <= wr_ptr + 1'b1;
            end

            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            pre_q  <= pre_len;
                            post_q <= post_len;
                            mask_q <= trig_mask;
                            val_q  <= trig_val;
                            wr_ptr <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            state  <= (pre_len == '0) ? ST_ARMED : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (bus.sample_en) begin
                            if (cnt + 1'b1 == pre_q)
                                state <= ST_ARMED;
                            else
                                cnt <= cnt + 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (bus.sample_en && hit) begin
                            trig_addr <= wr_ptr;
                            if (post_q == '0) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                cnt   <= post_q;
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        // cnt holds the number of post samples still owed
                        if (bus.sample_en) begin
                            if (cnt == ADDR_W'(1)) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
